// File: rtl/ldm_seq.sv
// LDM/STM micro-op sequencer: walks a 16-bit register list lowest-first,
// emitting one address per accepted transfer, then an optional base writeback.
module ldm_seq #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   reglist,
  input  logic [AW-1:0] base,
  input  logic          pre,
  input  logic          up,
  input  logic          wb,
  input  logic          load,
  input  logic          mem_ready,
  output logic          stall,
  output logic          uop_valid,
  output logic [3:0]    uop_reg,
  output logic [AW-1:0] uop_addr,
  output logic          uop_load,
  output logic          uop_last,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr
);

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  state_t        state, state_nx;
  logic [15:0]   pend;
  logic [AW-1:0] addr, fin_addr;
  logic          load_q, wb_q;

  logic [4:0]    cnt;
  logic [AW-1:0] off, addr_init, fin_init;
  logic [3:0]    idx;
  logic          last;

  // Start/final addresses from the incoming list; all arithmetic wraps mod 2^AW.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(reglist[i]);
    off = AW'({cnt, 2'b00});
    case ({pre, up})
      2'b01:   addr_init = base;
      2'b11:   addr_init = base + AW'(4);
      2'b00:   addr_init = base - off + AW'(4);
      default: addr_init = base - off;
    endcase
    fin_init = up ? base + off : base - off;
  end

  // Lowest pending register goes first, so it lands at the lowest address.
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) if (pend[i]) idx = 4'(i);
    last = (pend != '0) && ((pend & (pend - 16'd1)) == '0);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
              if (reglist != '0) state_nx = XFER;
              else if (wb)       state_nx = WB;
            end
      XFER: if (mem_ready && last) state_nx = wb_q ? WB : IDLE;
      WB:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from state so they read zero outside their phase.
  always_comb begin
    stall     = (state != IDLE);
    uop_valid = 1'b0;
    uop_reg   = '0;
    uop_addr  = '0;
    uop_load  = 1'b0;
    uop_last  = 1'b0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    if (state == XFER) begin
      uop_valid = 1'b1;
      uop_reg   = idx;
      uop_addr  = addr;
      uop_load  = load_q;
      uop_last  = last;
    end
    if (state == WB) begin
      wb_valid = 1'b1;
      wb_addr  = fin_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      addr     <= '0;
      fin_addr <= '0;
      load_q   <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
                pend     <= reglist;
                addr     <= addr_init;
                fin_addr <= fin_init;
                load_q   <= load;
                wb_q     <= wb;
              end
        XFER: if (mem_ready) begin
                pend <= pend & (pend - 16'd1);
                addr <= addr + AW'(4);
              end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_seq.sv
// Directed bench for ldm_seq: expected uops/writebacks are queued at issue
// and popped as the sequencer presents accepted transfers.
module tb_ldm_seq;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset, start, pre, up, wb, load, mem_ready;
  logic [15:0]   reglist;
  logic [AW-1:0] base;
  logic          stall, uop_valid, uop_load, uop_last, wb_valid;
  logic [3:0]    uop_reg;
  logic [AW-1:0] uop_addr, wb_addr;

  typedef struct packed {
    logic [3:0]    r;
    logic [AW-1:0] a;
    logic          last;
    logic          ld;
  } uop_t;

  uop_t          uq[$];
  logic [AW-1:0] wq[$];
  int checks = 0, failures = 0;

  ldm_seq #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .reglist(reglist), .base(base),
    .pre(pre), .up(up), .wb(wb), .load(load), .mem_ready(mem_ready),
    .stall(stall), .uop_valid(uop_valid), .uop_reg(uop_reg), .uop_addr(uop_addr),
    .uop_load(uop_load), .uop_last(uop_last), .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Compare whatever the DUT presents this cycle against the scoreboard.
  task automatic mon();
    uop_t e;
    logic [AW-1:0] w;
    if (uop_valid === 1'b1) begin
      if (mem_ready === 1'b1) begin
        checks++;
        assert (uq.size() != 0) else begin
          failures++;
          $error("FAIL uop_unexp obs=r%0d@%h exp=none", uop_reg, uop_addr);
        end
        if (uq.size() != 0) begin
          e = uq.pop_front();
          chk("uop_reg",  64'(uop_reg),  64'(e.r));
          chk("uop_addr", 64'(uop_addr), 64'(e.a));
          chk("uop_last", 64'(uop_last), 64'(e.last));
          chk("uop_load", 64'(uop_load), 64'(e.ld));
        end
      end
    end else begin
      chk("uop_idle", 64'({uop_valid, uop_reg, uop_addr, uop_load, uop_last}), 64'(0));
    end
    if (wb_valid === 1'b1) begin
      checks++;
      assert (wq.size() != 0) else begin
        failures++;
        $error("FAIL wb_unexp obs=%h exp=none", wb_addr);
      end
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wb_addr", 64'(wb_addr), 64'(w));
      end
    end else begin
      chk("wb_idle", 64'({wb_valid, wb_addr}), 64'(0));
    end
  endtask

  task automatic cycle();
    mon();
    @(posedge clk);
    #1;
  endtask

  // Reference model: registers ascending from the lowest address of the block.
  task automatic issue(input logic [15:0] rl, input logic [AW-1:0] b,
                       input logic p, input logic u, input logic w, input logic l);
    int n, k;
    logic [AW-1:0] a;
    uop_t e;
    n = $countones(rl);
    if (u) a = b + (p ? AW'(4) : AW'(0));
    else   a = b - AW'(4 * n) + (p ? AW'(0) : AW'(4));
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (rl[i]) begin
        e.r = 4'(i); e.a = a; e.last = (k == n - 1); e.ld = l;
        uq.push_back(e);
        a = a + AW'(4);
        k++;
      end
    end
    if (w) wq.push_back(u ? b + AW'(4 * n) : b - AW'(4 * n));
    reglist = rl; base = b; pre = p; up = u; wb = w; load = l; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int exp_stall);
    int cnt = 0;
    int guard = 0;
    while (stall === 1'b1 && guard < 200) begin
      cnt++; guard++;
      cycle();
    end
    chk({tag, "_stall_cycles"}, 64'(cnt), 64'(exp_stall));
    chk({tag, "_uq_empty"}, 64'(uq.size()), 64'(0));
    chk({tag, "_wq_empty"}, 64'(wq.size()), 64'(0));
    cycle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; reglist = '0; base = '0;
    pre = 1'b0; up = 1'b0; wb = 1'b0; load = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_uop", 64'({uop_valid, uop_reg, uop_addr, uop_load, uop_last}), 64'(0));
    chk("rst_wb", 64'({wb_valid, wb_addr}), 64'(0));
    reset = 1'b0;
    cycle();

    // IA with writeback
    issue(16'h0005, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b1);
    drain("ia", 3);

    // DB store with writeback
    issue(16'h8003, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0);
    drain("db", 4);

    // DA load, no writeback
    issue(16'h0110, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("da", 2);

    // IA with misaligned base: low bits carry through
    issue(16'h0402, 32'h1002, 1'b0, 1'b1, 1'b1, 1'b1);
    drain("ia_lowbits", 3);

    // IB with backpressure and ignored start pulses
    issue(16'h0003, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b1);
    mem_ready = 1'b0; start = 1'b1; reglist = 16'h00F0; base = 32'h9000;
    for (int i = 0; i < 2; i++) begin
      chk("bp_valid", 64'(uop_valid), 64'(1));
      chk("bp_reg",   64'(uop_reg),   64'(0));
      chk("bp_addr",  64'(uop_addr),  64'(32'h104));
      chk("bp_last",  64'(uop_last),  64'(0));
      cycle();
    end
    mem_ready = 1'b1; start = 1'b0;
    drain("bp", 3);

    // Empty list with and without writeback
    issue(16'h0000, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    drain("empty_wb", 1);
    issue(16'h0000, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("empty_nowb", 0);

    // Full list wrapping through zero
    issue(16'hFFFF, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1, 1'b1);
    drain("wrap", 17);

    // Reset mid-sequence after two transfers
    issue(16'h00FF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle();
    cycle();
    mem_ready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    chk("mid_rst_stall", 64'(stall), 64'(0));
    chk("mid_rst_uop", 64'({uop_valid, uop_reg, uop_addr, uop_load, uop_last}), 64'(0));
    chk("mid_rst_wb", 64'({wb_valid, wb_addr}), 64'(0));
    uq.delete();
    wq.delete();
    for (int i = 0; i < 3; i++) cycle();
    issue(16'h0081, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0);
    drain("post_rst", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldm_seq.md
Name: ldm_seq

Overview:
- Micro-op sequencer for ARM-style block transfers (LDM/STM) in decode.
- Takes a decoded 16-bit register list, base address and P/U/W/L mode bits.
- Emits one register transfer per accepted cycle, lowest register index at the lowest address, followed by an optional base writeback.
- Holds the front end stalled until the sequence retires.

Parameters:
AW, 32, address/base width in bits (word-aligned, 4-byte step)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  decoded LDM/STM valid; sampled only in IDLE
reglist  in  16  register list, bit i = Ri
base  in  AW  base register value
pre  in  1  P bit: 1 = adjust before transfer
up  in  1  U bit: 1 = increment, 0 = decrement
wb  in  1  W bit: write final address back to base
load  in  1  L bit: 1 = LDM, 0 = STM
mem_ready  in  1  memory stage accepts the current uop
stall  out  1  hold fetch/decode
uop_valid  out  1  transfer uop presented
uop_reg  out  4  register index of current uop
uop_addr  out  AW  address of current uop
uop_load  out  1  latched L bit
uop_last  out  1  current uop is the final transfer
wb_valid  out  1  one-cycle base writeback strobe
wb_addr  out  AW  writeback value

Behaviour:
- Clock is clk. Reset is synchronous and active-high (port reset). Single clock domain.
- FSM states: IDLE, XFER, WB.
  - IDLE: start=1 latches pend<=reglist, n<=popcount(reglist), load, wb. Computes addr and final address, both mod 2^AW:
    - IA (P=0,U=1): addr = base
    - IB (P=1,U=1): addr = base+4
    - DA (P=0,U=0): addr = base-4n+4
    - DB (P=1,U=0): addr = base-4n
    - final = U ? base+4n : base-4n
    - Next state: XFER if reglist != 0; else WB if wb; else stay in IDLE.
  - XFER: uop_valid=1. uop_reg = index of the lowest set bit of pend. uop_addr = addr. uop_last = (pend has exactly one bit set).
    - On uop_valid && mem_ready: clear that bit, addr <= addr+4.
    - If it was the last uop: go to WB if wb, else IDLE.
    - When mem_ready=0, all uop outputs hold stable.
  - WB: wb_valid=1 for exactly one cycle, wb_addr=final, then go to IDLE.
- stall = (state != IDLE). start is ignored while stall=1. Upstream must hold the instruction.
- Latency:
  - start at cycle t gives the first uop_valid at t+1.
  - With mem_ready held at 1, n uops occupy t+1..t+n. wb_valid then asserts at t+n+1.
- Empty list:
  - No uops are issued.
  - If wb: WB at t+1 with wb_addr=base (n=0).
  - If not wb: no visible effect, stall stays 0.
- Address arithmetic wraps modulo 2^AW. No fault is signalled. Low two bits of base pass through unchanged.
- Reset, including mid-sequence:
  - Next state is IDLE; pend, addr, final cleared to 0.
  - All outputs 0 (stall, uop_valid, uop_reg, uop_addr, uop_load, uop_last, wb_valid, wb_addr).
  - A partial sequence is abandoned; no writeback.
- uop_reg, uop_addr, uop_load and uop_last are 0 whenever uop_valid=0. wb_addr is 0 whenever wb_valid=0.
- Storage: pend 16 bits, addr/final AW bits, n 5 bits (max 16).

Test Plan:
- IA, reglist=0x0005, base=0x1000, wb=1, mem_ready=1: r0@0x1000 then r2@0x1004 with uop_last=1; wb_valid with wb_addr=0x1008; stall high for 3 cycles.
- DB, reglist=0x8003, base=0x2000, wb=1: r0@0x1FF4, r1@0x1FF8, r15@0x1FFC (last); wb_addr=0x1FF4.
- Backpressure, IB, reglist=0x0003, base=0x100, mem_ready low on cycles 1-2: r0@0x104 held stable for 3 cycles, then r1@0x108; start pulses while busy are ignored.
- Empty list: reglist=0, wb=1, base=0x40 gives one wb_valid with wb_addr=0x40 and no uop_valid. With wb=0: no outputs, stall=0.
- Wrap, IB, reglist=0xFFFF, base=0xFFFFFFF0: r0@0xFFFFFFF4, r3@0x00000000, r15@0x00000030 (last); wb_addr=0x00000030.
- Reset asserted after the 2nd uop of 0x00FF: next cycle all outputs 0, IDLE, no wb_valid. A new start is then accepted normally.
